// File: rtl/mlx5_cmd_pkg.sv
// Shared types and widths for the mlx5 command-string driver.
package mlx5_cmd_pkg;

    localparam int unsigned OPCODE_W = 32;
    localparam int unsigned STRPTR_W = 64;
    localparam int unsigned SEQ_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [STRPTR_W-1:0] strptr;
        logic [SEQ_W-1:0]    seq;
        logic                err;
    } result_t;

    function automatic result_t make_result(input logic [OPCODE_W-1:0] opcode,
                                            input logic [STRPTR_W-1:0] strptr,
                                            input logic [SEQ_W-1:0]    seq,
                                            input logic                err);
        result_t r;
        r.opcode = opcode;
        r.strptr = strptr;
        r.seq    = seq;
        r.err    = err;
        return r;
    endfunction

endpackage

// File: rtl/mlx5_cmd_fifo.sv
// Opcode FIFO with registered full/empty flags; depth must be a power of two.
module mlx5_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    // full resets high so nothing is accepted until the first clock after reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/mlx5_cmd_str_driver.sv
// Drives opcodes one at a time through the string-lookup component and streams results out.
// Optional watchdog: define MLX5_CMD_STR_DRIVER_WATCHDOG_EN.
module mlx5_cmd_str_driver
    import mlx5_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    output logic                start,
    output logic [OPCODE_W-1:0] command,
    input  logic                busy,
    input  logic                done,
    output logic                stall,
    input  logic [STRPTR_W-1:0] returndata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [STRPTR_W-1:0] out_strptr,
    output logic [SEQ_W-1:0]    out_seq,
    output logic                out_err
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("mlx5_cmd_str_driver: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] cmd_q, cmd_d;
    result_t             res_q, res_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                start_q;
    logic                out_valid_q;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OPCODE_W-1:0] fifo_rdata;
    logic                timeout_c;

    mlx5_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OPCODE_W)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (in_valid),
        .wdata  (in_opcode),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef MLX5_CMD_STR_DRIVER_WATCHDOG_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    logic [WD_W-1:0] wd_q;

    // counts every cycle a command is in flight; cleared whenever the FSM leaves ISSUE/WAIT
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_q <= '0;
        end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
            wd_q <= wd_q + WD_W'(1);
        end else begin
            wd_q <= '0;
        end
    end

    assign timeout_c = (wd_q == WD_W'(TIMEOUT_CYCLES));
`else
    assign timeout_c = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        res_d    = res_q;
        seq_d    = seq_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!busy) begin
                    state_d = ST_WAIT;
                end else if (timeout_c) begin
                    res_d   = make_result(cmd_q, '0, seq_q, 1'b1);
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    res_d   = make_result(cmd_q, returndata, seq_q, 1'b0);
                    state_d = ST_HOLD;
                end else if (timeout_c) begin
                    res_d   = make_result(cmd_q, '0, seq_q, 1'b1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            res_q       <= '0;
            seq_q       <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            res_q       <= res_d;
            seq_q       <= seq_d;
            start_q     <= (state_d == ST_ISSUE);
            out_valid_q <= (state_d == ST_HOLD);
        end
    end

    assign in_ready   = ~fifo_full;
    assign start      = start_q;
    assign command    = cmd_q;
    assign stall      = (state_q == ST_HOLD) & ~out_ready;
    assign out_valid  = out_valid_q;
    assign out_opcode = res_q.opcode;
    assign out_strptr = res_q.strptr;
    assign out_seq    = res_q.seq;
    // err is only ever loaded with 1 on a watchdog expiry, so without the watchdog it stays 0
    assign out_err    = res_q.err;

`ifndef SYNTHESIS
    // done pulses arriving outside WAIT are dropped; tallied for simulation only
    int unsigned ignored_done_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ignored_done_q <= 0;
        end else if (done && state_q != ST_WAIT) begin
            ignored_done_q <= ignored_done_q + 1;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            assert (ignored_done_q != 32'hFFFF_FFFF);
            assert (!out_valid_q || state_q == ST_HOLD);
        end
    end
`endif

endmodule

// File: tb/tb_mlx5_cmd_str_driver.sv
// Self-checking bench for mlx5_cmd_str_driver: vector table, component model and result scoreboard.
module tb_mlx5_cmd_str_driver;

    typedef struct {
        logic [31:0] op;
        int          lat;
        int          bp;
        logic [63:0] exp_sp;
    } vec_t;

    typedef struct {
        logic [31:0] op;
        logic [63:0] sp;
        logic [7:0]  seq;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid, in_ready;
    logic [31:0] in_opcode;
    logic        start, busy, done, stall;
    logic [31:0] command;
    logic [63:0] returndata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_opcode;
    logic [63:0] out_strptr;
    logic [7:0]  out_seq;

    int          vec_cnt = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    logic [7:0]  exp_seq = 8'd0;

    int          comp_lat = 1;
    int          bp_knob = 0;
    bit          mute = 1'b0;
    int          inject_req = 0;
    int          accept_cnt = 0;
    vec_t        vecs[8];

    always #5 clock = ~clock;

    mlx5_cmd_str_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(1023)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .start      (start),
        .command    (command),
        .busy       (busy),
        .done       (done),
        .stall      (stall),
        .returndata (returndata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_strptr (out_strptr),
        .out_seq    (out_seq),
        .out_err    (out_err)
    );

    function automatic logic [63:0] strp(input logic [31:0] op);
        return {(op & 32'hFFFF_FF00) ^ 32'h0000_0100, 32'h0000_A000 + {21'd0, op[7:0], 3'b000}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] op, input logic [63:0] sp, input logic err);
        int g = 0;
        @(negedge clock);
        in_valid  = 1'b1;
        in_opcode = op;
        while (!in_ready && g < 400) begin
            @(negedge clock);
            g++;
        end
        chk("push_ready", 64'(in_ready), 64'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{op, sp, exp_seq, err});
        exp_seq++;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int g = 0;
        while (exp_q.size() != 0 && g < budget) begin
            @(negedge clock);
            g++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // string-lookup component: accepts on start && !busy, answers after comp_lat cycles
    initial begin
        bit          pend = 1'b0;
        bit          acc;
        int          lat_left = 0;
        int          inj_seen = 0;
        logic [31:0] cmd_s;
        done = 1'b0;
        returndata = '0;
        forever begin
            @(negedge clock);
            #2;
            acc   = resetn && start && !busy;
            cmd_s = command;
            if (!resetn) pend = 1'b0;
            if (acc) accept_cnt++;
            @(posedge clock);
            #1;
            done = 1'b0;
            if (pend) begin
                if (lat_left <= 0) begin
                    done       = 1'b1;
                    returndata = strp(cmd_s);
                    pend       = 1'b0;
                end else begin
                    lat_left--;
                end
            end else if (inject_req != inj_seen) begin
                inj_seen   = inject_req;
                done       = 1'b1;
                returndata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (acc && !mute) begin
                pend     = 1'b1;
                lat_left = comp_lat - 1;
            end
        end
    end

    // result sink with programmable backpressure; pops the scoreboard on each handshake
    initial begin
        bit          waiting = 1'b0;
        bit          have_snap = 1'b0;
        int          hold_left = 0;
        exp_t        e;
        logic [31:0] s_op;
        logic [63:0] s_sp;
        logic [7:0]  s_seq;
        logic        s_err;
        out_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (out_valid && !waiting) begin
                waiting   = 1'b1;
                hold_left = bp_knob;
            end
            out_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            #1;
            chk("stall", 64'(stall), 64'(out_valid && !out_ready));
            if (out_valid && have_snap) begin
                chk("hold_opcode", 64'(out_opcode), 64'(s_op));
                chk("hold_strptr", out_strptr, s_sp);
                chk("hold_seq", 64'(out_seq), 64'(s_seq));
                chk("hold_err", 64'(out_err), 64'(s_err));
            end
            have_snap = out_valid && !out_ready;
            s_op = out_opcode; s_sp = out_strptr; s_seq = out_seq; s_err = out_err;
            if (!resetn) waiting = 1'b0;
            if (out_valid && out_ready) begin
                waiting = 1'b0;
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    miscompares++;
                    $display("FAIL unexpected_result: got opcode 0x%0h, expected no result", out_opcode);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_opcode", 64'(out_opcode), 64'(e.op));
                    chk("out_strptr", out_strptr, e.sp);
                    chk("out_seq", 64'(out_seq), 64'(e.seq));
                    chk("out_err", 64'(out_err), 64'(e.err));
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_start"}, 64'(start), 64'd0);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_err"}, 64'(out_err), 64'd0);
        chk({tag, "_command"}, 64'(command), 64'd0);
        chk({tag, "_out_opcode"}, 64'(out_opcode), 64'd0);
        chk({tag, "_out_strptr"}, out_strptr, 64'd0);
        chk({tag, "_out_seq"}, 64'(out_seq), 64'd0);
    endtask

    initial begin
        int acc0;
        int g;
        in_valid  = 1'b0;
        in_opcode = '0;
        busy      = 1'b0;

        vecs[0] = '{32'h0000_0100, 5, 0,  64'h0000_0000_0000_A000};
        vecs[1] = '{32'h0000_0101, 5, 0,  64'h0000_0000_0000_A008};
        vecs[2] = '{32'h0000_01FF, 1, 0,  64'h0000_0000_0000_A7F8};
        vecs[3] = '{32'h0000_0000, 3, 2,  64'h0000_0100_0000_A000};
        vecs[4] = '{32'hDEAD_BEEF, 2, 10, 64'hDEAD_BF00_0000_A778};
        vecs[5] = '{32'h1234_5680, 7, 1,  64'h1234_5700_0000_A400};
        vecs[6] = '{32'hFFFF_FFFF, 1, 0,  64'hFFFF_FE00_0000_A7F8};
        vecs[7] = '{32'h0000_0200, 4, 3,  64'h0000_0300_0000_A000};

        #1 resetn = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[i]) begin
            comp_lat = vecs[i].lat;
            bp_knob  = vecs[i].bp;
            push(vecs[i].op, vecs[i].exp_sp, 1'b0);
            drain(200);
        end
        bp_knob  = 0;
        comp_lat = 2;

        // component busy while the request is presented
        busy = 1'b1;
        acc0 = accept_cnt;
        push(32'h0000_0300, strp(32'h0000_0300), 1'b0);
        g = 0;
        while (!start && g < 20) begin
            @(negedge clock);
            g++;
        end
        repeat (7) begin
            @(negedge clock);
            #1;
            chk("busy_start", 64'(start), 64'd1);
            chk("busy_command", 64'(command), 64'h300);
            chk("busy_no_accept", 64'(accept_cnt), 64'(acc0));
        end
        busy = 1'b0;
        drain(100);

        // fill the FIFO behind a stalled component
        busy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(i), strp(32'h400 + 32'(i)), 1'b0);
        @(negedge clock);
        #1 chk("fifo_not_full", 64'(in_ready), 64'd1);
        push(32'h404, strp(32'h404), 1'b0);
        @(negedge clock);
        #1 chk("fifo_full", 64'(in_ready), 64'd0);
        chk("fifo_cmd_held", 64'(command), 64'h400);
        busy = 1'b0;
        push(32'h405, strp(32'h405), 1'b0);
        drain(300);

        // stray done while idle must not create a result
        inject_req++;
        repeat (10) @(negedge clock);
        #1 chk("stray_done", 64'(out_valid), 64'd0);

        // 256 commands so the sequence number wraps
        comp_lat = 1;
        for (int i = 0; i < 256; i++) push(32'h1000 + 32'(i), strp(32'h1000 + 32'(i)), 1'b0);
        drain(3000);

        // reset while a command is outstanding in WAIT
        comp_lat = 40;
        acc0 = accept_cnt;
        push(32'h500, strp(32'h500), 1'b0);
        g = 0;
        while (accept_cnt == acc0 && g < 20) begin
            @(negedge clock);
            g++;
        end
        repeat (3) @(negedge clock);
        #3 resetn = 1'b0;
        #1 chk_reset_outputs("midreset");
        exp_q.delete();
        exp_seq = 8'd0;
        repeat (2) @(negedge clock);
        #3 resetn = 1'b1;
        comp_lat = 2;
        push(32'h501, strp(32'h501), 1'b0);
        drain(100);

`ifdef MLX5_CMD_STR_DRIVER_WATCHDOG_EN
        mute = 1'b1;
        push(32'h600, 64'd0, 1'b1);
        drain(1300);
        mute = 1'b0;
`endif

        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/mlx5_cmd_str_driver.md
MLX5_CMD_STR_DRIVER -- requirements
Module: mlx5_cmd_str_driver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of opcode entries buffered ahead of the string-lookup component (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the watchdog limit in cycles; it is used only when the watchdog is compiled in.
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_opcode (input, 32), forming the upstream opcode stream; a transfer occurs when in_valid and in_ready are both 1.
REQ-006 SHALL have the component-side ports start (output, 1), command (output, 32), busy (input, 1), done (input, 1), stall (output, 1) and returndata (input, 64).
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_opcode (output, 32), out_strptr (output, 64), out_seq (output, 8) and out_err (output, 1), forming the downstream result stream.

Function
REQ-008 SHALL store accepted opcodes in a FIFO_DEPTH-entry FIFO; in_ready = 1 when the FIFO is not full; a simultaneous push and pop while full is not permitted, because in_ready is already 0.
REQ-009 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> HOLD -> IDLE, with exactly one command outstanding at the component.
REQ-010 IDLE: when the FIFO is non-empty, pop the head into cmd_reg and go to ISSUE on the next cycle.
REQ-011 ISSUE: hold start = 1 and command = cmd_reg; the request is accepted in the cycle where start = 1 and busy = 0; in that cycle go to WAIT; command SHALL stay stable while busy = 1.
REQ-012 WAIT: start = 0 and stall = 0; on done = 1, capture returndata into out_strptr, set out_opcode = cmd_reg, out_seq = seq_cnt and out_err = 0, then go to HOLD.
REQ-013 HOLD: out_valid = 1; on out_ready = 1, increment seq_cnt (8-bit, wraps 255 -> 0) and go to IDLE.
REQ-014 stall SHALL be 1 only while in HOLD with out_ready = 0; the component result SHALL never be dropped.
REQ-015 out_* fields SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-016 Minimum latency from FIFO pop to out_valid SHALL be 3 cycles plus the component latency; with out_ready held at 1 and busy held at 0, one result SHALL be produced per (component latency + 4) cycles.
REQ-017 A done pulse seen outside WAIT SHALL be ignored; the ignored-done count is visible only in simulation assertions.

Reset
REQ-018 On resetn = 0, immediately and asynchronously: FSM = IDLE, FIFO empty, seq_cnt = 0, start = 0, stall = 0, out_valid = 0, out_err = 0, command = 0, out_opcode = 0, out_strptr = 0, out_seq = 0, and in_ready = 0 while resetn is low.
REQ-019 Reset asserted mid-operation SHALL discard any outstanding command and any held result; the component is reset by the same resetn.

Configuration
REQ-020 Macro MLX5_CMD_STR_DRIVER_WATCHDOG_EN defined: a 10-bit-minimum counter runs in ISSUE and WAIT; on reaching TIMEOUT_CYCLES the block enters HOLD with out_strptr = 0, out_err = 1 and out_opcode = cmd_reg.
REQ-021 Macro MLX5_CMD_STR_DRIVER_WATCHDOG_EN undefined: no counter is present, out_err is tied to 0, and the FSM waits indefinitely.

Structure
REQ-022 Shared package mlx5_cmd_pkg SHALL hold the FSM state enum, OPCODE_W = 32, STRPTR_W = 64 and SEQ_W = 8.
REQ-023 The FIFO SHALL be a separate sub-module mlx5_cmd_fifo (parameterised depth and width, registered full/empty flags); the FSM and output registers stay in the top module.

Verification
REQ-024 Push opcodes 0x100 and 0x101 with busy = 0 and done 5 cycles after accept returning 0xA000/0xA008 -> out_seq 0 then 1 in order, out_strptr matching, out_err = 0.
REQ-025 Hold busy = 1 for 7 cycles during ISSUE -> start stays 1, command stays constant, and no WAIT entry before busy falls.
REQ-026 Hold out_ready = 0 for 10 cycles when done arrives -> stall = 1 for that whole time, out_* stable, no result lost after release.
REQ-027 Push 6 opcodes back-to-back with FIFO_DEPTH = 4 and the component stalled -> in_ready = 0 after the FIFO holds 4 entries while a fifth is held in cmd_reg, and all 6 results eventually emerge in order.
REQ-028 Drive 256 commands -> out_seq wraps 255 -> 0; with the watchdog compiled in, done never asserted for 1023 cycles -> out_err = 1 and out_strptr = 0.
REQ-029 Assert resetn = 0 while in WAIT -> all outputs equal their reset values immediately, and the first command after reset gets out_seq 0.
